// File: rtl/counter_pkg.sv
// Shared constants and step arithmetic for param_updown_counter.
package counter_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Internal arithmetic width; wide enough for WIDTH+1 bits at any legal WIDTH.
    localparam int unsigned CNT_W = 32;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic wrap;
        cnt_t value;
    } step_t;

    function automatic cnt_t clamp_load(cnt_t val, cnt_t modulus);
        cnt_t top;
        top = modulus - cnt_t'(1);
        return (val > top) ? top : val;
    endfunction

    // One modulo step in the requested direction; wrap flags the rollover.
    function automatic step_t next_count(cnt_t cnt, logic up, cnt_t modulus);
        step_t st;
        cnt_t  top;
        top      = modulus - cnt_t'(1);
        st.wrap  = 1'b0;
        st.value = cnt;
        if (up == DIR_UP) begin
            if (cnt == top) begin
                st.value = '0;
                st.wrap  = 1'b1;
            end else begin
                st.value = cnt + cnt_t'(1);
            end
        end else begin
            if (cnt == '0) begin
                st.value = top;
                st.wrap  = 1'b1;
            end else begin
                st.value = cnt - cnt_t'(1);
            end
        end
        return st;
    endfunction

endpackage

// File: rtl/counter_next_logic.sv
// Combinational next-count, wrap and terminal-count logic; priority clear > load > en.
// With COUNTER_SATURATE_EN the count holds at the terminal value and wrap_d_c flags the saturation.
module counter_next_logic
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 16
) (
    input  logic [WIDTH-1:0] counter,
    input  logic             up_dn,
    input  logic             en,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count_next_c,
    output logic             wrap_d_c,
    output logic             tc_c
);

    localparam cnt_t MOD = cnt_t'(MODULUS);
    localparam cnt_t TOP = MOD - cnt_t'(1);

    logic                   step_wrap;
    logic [CNT_W-WIDTH-1:0] step_hi_unused;
    logic [WIDTH-1:0]       step_val;
    logic [WIDTH-1:0]       load_clamped;

    // Step value always fits in WIDTH bits; the upper bits are zero by construction.
    assign {step_wrap, step_hi_unused, step_val} = next_count(cnt_t'(counter), up_dn, MOD);
    assign load_clamped = WIDTH'(clamp_load(cnt_t'(load_val), MOD));

    assign tc_c = ((up_dn == DIR_UP) && (cnt_t'(counter) == TOP)) ||
                  ((up_dn == DIR_DN) && (counter == '0));

    always_comb begin
        count_next_c = counter;
        wrap_d_c     = 1'b0;
        if (clear) begin
            count_next_c = '0;
        end else if (load) begin
            count_next_c = load_clamped;
        end else if (en) begin
`ifdef COUNTER_SATURATE_EN
            count_next_c = step_wrap ? counter : step_val;
`else
            count_next_c = step_val;
`endif
            wrap_d_c = step_wrap;
        end
    end

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised up/down modulo counter with clear, load, terminal count and wrap pulse.
// Define COUNTER_SATURATE_EN to saturate at the terminal value; wrap then carries the sat pulse.
module param_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] counter,
    output logic             tc,
    output logic             wrap
);

    localparam longint unsigned MOD_LIMIT = 64'(1) << WIDTH;

    if (WIDTH == 0 || WIDTH >= CNT_W) begin : g_bad_width
        $error("param_updown_counter: WIDTH must be in 1..%0d", CNT_W - 1);
    end
    if (MODULUS < 2 || 64'(MODULUS) > MOD_LIMIT) begin : g_bad_modulus
        $error("param_updown_counter: MODULUS must be in 2..2**WIDTH");
    end

    logic [WIDTH-1:0] count_next_c;
    logic             wrap_d_c;

    counter_next_logic #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .counter      (counter),
        .up_dn        (up_dn),
        .en           (en),
        .clear        (clear),
        .load         (load),
        .load_val     (load_val),
        .count_next_c (count_next_c),
        .wrap_d_c     (wrap_d_c),
        .tc_c         (tc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter <= '0;
            wrap    <= 1'b0;
        end else begin
            counter <= count_next_c;
            wrap    <= wrap_d_c;
        end
    end

endmodule
